// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK-cell sequencing controller: FSM states and
// count-direction encodings.
package jk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/jk_seq_ctrl_jk_cell.sv
// Single JK flip-flop: 00 hold, 01 reset, 10 set, 11 toggle, with a
// synchronous clear to Q=0 / Q_NOT=1.
module jk_cell (
    input  logic CLK,
    input  logic RST,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_NOT
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                2'b00:   Q <= Q;
                2'b01:   Q <= 1'b0;
                2'b10:   Q <= 1'b1;
                default: Q <= ~Q;
            endcase
        end
    end

    assign Q_NOT = ~Q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Run controller that loads and steps a bank of JK cells up to LIMIT or down
// from LIMIT to zero, purely by steering the cells' J/K inputs.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             DIR,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic             HOLD,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] JK_J,
    output logic [WIDTH-1:0] JK_K
);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] load_v;
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic             all_ones;
    logic             all_zeros;
    logic             at_term;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            dir_q   <= DIR_UP;
            limit_q <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        dir_q   <= DIR;
                        limit_q <= LIMIT;
                        BUSY    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    if (!HOLD && at_term) begin
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Toggle masks: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_t      = '0;
        dn_t      = '0;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i]   = all_ones;
            dn_t[i]   = all_zeros;
            all_ones  = all_ones & COUNT[i];
            all_zeros = all_zeros & count_n[i];
        end
    end

    assign at_term = (dir_q == DIR_UP) ? (COUNT == limit_q) : (&count_n);
    assign load_v  = (dir_q == DIR_UP) ? '0 : limit_q;

    always_comb begin
        JK_J = '0;
        JK_K = '0;
        case (state)
            LOAD: begin
                JK_J = load_v;
                JK_K = ~load_v;
            end
            RUN: begin
                if (!HOLD && !at_term) begin
                    JK_J = (dir_q == DIR_UP) ? up_t : dn_t;
                    JK_K = (dir_q == DIR_UP) ? up_t : dn_t;
                end
            end
            default: begin
                JK_J = '0;
                JK_K = '0;
            end
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .CLK   (CLK),
            .RST   (RST),
            .J     (JK_J[g]),
            .K     (JK_K[g]),
            .Q     (COUNT[g]),
            .Q_NOT (count_n[g])
        );
    end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl: expected COUNT traces are queued when a run
// is started and popped edge by edge as the cell bank advances.
module tb_jk_seq_ctrl;
    import jk_seq_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dir;
    logic [W-1:0] limit;
    logic         hold;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic [W-1:0] jk_j;
    logic [W-1:0] jk_k;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    jk_seq_ctrl #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .DIR   (dir),
        .LIMIT (limit),
        .HOLD  (hold),
        .COUNT (count),
        .BUSY  (busy),
        .DONE  (done),
        .JK_J  (jk_j),
        .JK_K  (jk_k)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a run just after an edge k and follow it edge by edge to the end.
    task automatic run(input logic d, input int lim, input int hold_val,
                       input int hold_len, input bit stray);
        int n;
        int hpos;
        int last;
        logic [W-1:0] v;
        logic [W-1:0] lv;
        logic [W-1:0] fin;
        n    = (hold_val >= 0) ? hold_len : 0;
        hpos = (d == DIR_UP) ? hold_val : lim - hold_val;
        last = 3 + lim + n;
        lv   = (d == DIR_UP) ? '0 : W'(lim);
        fin  = (d == DIR_UP) ? W'(lim) : '0;
        for (int s = 0; s <= lim; s++) begin
            v = (d == DIR_UP) ? W'(s) : W'(lim - s);
            exp_q.push_back(v);
            if (int'(v) == hold_val) repeat (n) exp_q.push_back(v);
        end
        @(posedge clk); #1;
        start = 1'b1;
        dir   = d;
        limit = W'(lim);
        for (int j = 1; j <= last + 3; j++) begin
            @(posedge clk); #1;
            if (j == 1) start = 1'b0;
            if (stray && j == 4) begin
                start = 1'b1;
                dir   = ~d;
                limit = 4'd3;
            end
            if (stray && j == 5) start = 1'b0;
            if (n > 0 && j == 2 + hpos) hold = 1'b1;
            if (n > 0 && j == 2 + hpos + n) hold = 1'b0;
            #1;
            if (j == 1) begin
                check("load_j", 16'(jk_j), 16'(lv));
                check("load_k", 16'(jk_k), 16'(W'(~lv)));
            end
            if (j >= 2 && j <= 2 + lim + n) begin
                if (exp_q.size() > 0) check("count", 16'(count), 16'(exp_q.pop_front()));
                else check("exp_q_underflow", 16'(exp_q.size()), 16'd1);
            end
            if (n > 0 && j >= 2 + hpos && j < 2 + hpos + n) begin
                check("hold_j", 16'(jk_j), 16'd0);
                check("hold_k", 16'(jk_k), 16'd0);
            end
            check("done", 16'(done), 16'(j == last));
            check("busy", 16'(busy), 16'(j <= last));
        end
        check("count_final", 16'(count), 16'(fin));
        check("exp_q_empty", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        dir   = 1'b0;
        limit = '0;
        hold  = 1'b0;

        // Reset with START held high: reset must win.
        repeat (2) @(posedge clk);
        #2;
        check("rst_count", 16'(count), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_j", 16'(jk_j), 16'd0);
        check("rst_k", 16'(jk_k), 16'd0);
        check("rst_state", 16'(dut.state), 16'(IDLE));
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("idle_busy", 16'(busy), 16'd0);

        run(DIR_UP, 5, -1, 0, 1'b0);
        run(DIR_DOWN, 9, -1, 0, 1'b1);
        run(DIR_UP, 0, -1, 0, 1'b0);
        run(DIR_UP, 15, -1, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("no_wrap", 16'(count), 16'd15);
        run(DIR_UP, 7, 3, 3, 1'b0);

        // Mid-run reset at COUNT=6 of an up run to 12.
        @(posedge clk); #1;
        start = 1'b1;
        dir   = DIR_UP;
        limit = 4'd12;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); #1;
            if (j == 1) start = 1'b0;
            if (j == 9) rst = 1'b0;
            #1;
            if (j == 8) begin
                check("pre_rst_count", 16'(count), 16'd6);
                rst = 1'b1;
            end
            if (j == 9) begin
                check("post_rst_count", 16'(count), 16'd0);
                check("post_rst_busy", 16'(busy), 16'd0);
                check("post_rst_state", 16'(dut.state), 16'(IDLE));
            end
            if (j >= 2) check("mid_rst_done", 16'(done), 16'd0);
        end
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #2;
            check("aborted_done", 16'(done), 16'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
